uart_rx: RTL and testbench

- Serial UART receiver. It is the downstream counterpart of the team's uart_tx and consumes the serial line that uart_tx drives.
- Format: 8N1 or more stop bits, LSB first, idle-high line.
- Oversamples the line with the system clock, samples each bit at mid-period, and presents each received byte with a one-cycle done tick.
- Flags a framing error when the stop bit is low.

---
 rtl/uart_rx.sv | 131 +++++++++++++
 tb/tb_uart_rx.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver, mid-bit sampling, done tick and framing-error pulse
module uart_rx #(
  parameter int c_clkfreq  = 100_000_000,
  parameter int c_baudrate = 10_000_000
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       rx_i,
  output logic [7:0] rx_dout_o,
  output logic       rx_done_tick_o,
  output logic       rx_active_o,
  output logic       frame_err_o
);

  localparam int          c_timerlim = c_clkfreq / c_baudrate;
  localparam logic [31:0] c_half_lim = 32'(c_timerlim / 2 - 1);
  localparam logic [31:0] c_bit_lim  = 32'(c_timerlim - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

  state_t      state_q, state_d;
  logic [31:0] timer_q, timer_d;
  logic [2:0]  bitcnt_q, bitcnt_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [7:0]  dout_q, dout_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        sync1_q, rx_s;

  // Reset to the idle level so a reset never fabricates a start bit.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      sync1_q <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      sync1_q <= rx_i;
      rx_s    <= sync1_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q  <= S_IDLE;
      timer_q  <= '0;
      bitcnt_q <= '0;
      shreg_q  <= '0;
      dout_q   <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      bitcnt_q <= bitcnt_d;
      shreg_q  <= shreg_d;
      dout_q   <= dout_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    bitcnt_d = bitcnt_q;
    shreg_d  = shreg_q;
    dout_d   = dout_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!rx_s) begin
          state_d = S_START;
          timer_d = '0;
        end
      end
      S_START: begin
        if (timer_q == c_half_lim) begin
          timer_d = '0;
          if (!rx_s) begin
            state_d  = S_DATA;
            bitcnt_d = '0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
      S_DATA: begin
        if (timer_q == c_bit_lim) begin
          shreg_d = {rx_s, shreg_q[7:1]};
          timer_d = '0;
          if (bitcnt_q == 3'd7) begin
            state_d  = S_STOP;
            bitcnt_d = '0;
          end else begin
            bitcnt_d = bitcnt_q + 3'd1;
          end
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
      S_STOP: begin
        // Leaving at mid-stop-bit lets any number of stop bits follow.
        if (timer_q == c_bit_lim) begin
          timer_d = '0;
          if (rx_s) begin
            dout_d  = shreg_q;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            err_d   = 1'b1;
            state_d = S_BREAK;
          end
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
      S_BREAK: begin
        if (rx_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rx_dout_o      = dout_q;
  assign rx_done_tick_o = done_q;
  assign frame_err_o    = err_q;
  assign rx_active_o    = (state_q == S_START) || (state_q == S_DATA) || (state_q == S_STOP);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard bench for uart_rx with a fractional-baud serial driver
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rstn;
  logic       rx;
  logic [7:0] dout;
  logic       done;
  logic       active;
  logic       ferr;

  uart_rx #(.c_clkfreq(100_000_000), .c_baudrate(10_000_000)) dut (
    .clk_i(clk),
    .rstn_i(rstn),
    .rx_i(rx),
    .rx_dout_o(dout),
    .rx_done_tick_o(done),
    .rx_active_o(active),
    .frame_err_o(ferr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         n_pass = 0;
  int         n_total = 0;
  logic [7:0] exp_q[$];
  int         err_exp = 0;
  logic [7:0] last_good = 8'h00;
  int         start_cyc = 0;
  int         tick_cyc = 0;
  int         act_rise = 0;
  int         act_fall = 0;
  logic       prev_done = 1'b0;
  logic       prev_err = 1'b0;
  logic       prev_active = 1'b0;

  task automatic check(input bit ok, input string name, input int act, input int req);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  // Reference frame: start(0), data LSB first, first stop bit.
  function automatic logic [9:0] make_frame(input logic [7:0] d, input bit stop_ok);
    return {stop_ok, d, 1'b0};
  endfunction

  task automatic expect_frame(input logic [9:0] f);
    if (f[9]) begin
      exp_q.push_back(f[8:1]);
      last_good = f[8:1];
    end else begin
      err_exp++;
    end
  endtask

  // Cell k spans clock edges [floor(k*cpb), floor((k+1)*cpb)) from the frame start.
  task automatic send_frame(input logic [7:0] d, input real cpb, input int nstop,
                            input bit stop_ok, input bit predict);
    logic [9:0] f;
    int hold;
    f = make_frame(d, stop_ok);
    if (predict) expect_frame(f);
    start_cyc = cyc;
    for (int k = 0; k < 9 + nstop; k++) begin
      rx = (k < 10) ? f[k] : 1'b1;
      hold = $rtoi((k + 1) * cpb) - $rtoi(k * cpb);
      repeat (hold) @(negedge clk);
    end
  endtask

  task automatic drain(input string name);
    repeat (30) @(negedge clk);
    check(exp_q.size() == 0, {name, "_bytes_outstanding"}, exp_q.size(), 0);
    check(err_exp == 0, {name, "_errors_outstanding"}, err_exp, 0);
    check(dout == last_good, {name, "_dout_held"}, dout, last_good);
  endtask

  always @(negedge clk) begin
    if (done) begin
      if (prev_done) check(1'b0, "tick_width", 2, 1);
      if (exp_q.size() == 0) begin
        check(1'b0, "unexpected_tick", dout, 0);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        check(dout == e, "rx_byte", dout, e);
      end
      tick_cyc = cyc;
    end
    if (ferr) begin
      if (prev_err) check(1'b0, "err_width", 2, 1);
      check(err_exp > 0, "frame_err_expected", 1, err_exp);
      if (err_exp > 0) err_exp--;
    end
    if (active && !prev_active) act_rise = cyc;
    if (!active && prev_active) act_fall = cyc;
    prev_done = done;
    prev_err = ferr;
    prev_active = active;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    logic [7:0] seq[3];
    real cpb;
    seq[0] = 8'h00; seq[1] = 8'hFF; seq[2] = 8'h3C;
    rstn = 1'b0;
    rx = 1'b1;
    repeat (3) @(negedge clk);
    check(dout == 8'h00, "reset_dout", dout, 0);
    check(done == 1'b0, "reset_done", done, 0);
    check(ferr == 1'b0, "reset_err", ferr, 0);
    check(active == 1'b0, "reset_active", active, 0);
    rstn = 1'b1;
    repeat (5) @(negedge clk);

    // Basic byte with latency and active-window checks
    send_frame(8'hA5, 10.0, 1, 1'b1, 1'b1);
    drain("basic");
    check(tick_cyc - start_cyc == 98, "tick_latency", tick_cyc - start_cyc, 98);
    check(act_rise - start_cyc == 3, "active_rise", act_rise - start_cyc, 3);
    check(act_fall - start_cyc == 98, "active_fall", act_fall - start_cyc, 98);

    // Back-to-back, two then one stop bits
    for (int ns = 2; ns >= 1; ns--) begin
      foreach (seq[i]) send_frame(seq[i], 10.0, ns, 1'b1, 1'b1);
      drain("b2b");
    end

    // Glitch rejection
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    drain("glitch");
    check(active == 1'b0, "glitch_idle", active, 0);

    // Framing error then held break
    send_frame(8'h55, 10.0, 1, 1'b0, 1'b1);
    rx = 1'b0;
    repeat (200) @(negedge clk);
    rx = 1'b1;
    drain("ferr");
    repeat (10) @(negedge clk);
    send_frame(8'h81, 10.0, 1, 1'b1, 1'b1);
    drain("after_break");

    // Reset during data bit 4; upper nibble high keeps the tail idle-like
    b = 8'hF0 | 8'($urandom_range(0, 15));
    fork
      send_frame(b, 10.0, 1, 1'b1, 1'b0);
      begin
        repeat (55) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        check(dout == 8'h00, "midreset_dout", dout, 0);
        check(active == 1'b0, "midreset_active", active, 0);
        check(done == 1'b0, "midreset_done", done, 0);
        check(ferr == 1'b0, "midreset_err", ferr, 0);
        last_good = 8'h00;
      end
    join
    drain("midreset_tail");
    send_frame(8'hC3, 10.0, 1, 1'b1, 1'b1);
    drain("after_reset");

    // Baud skew
    send_frame(8'h96, 9.7, 1, 1'b1, 1'b1);
    send_frame(8'h96, 9.7, 1, 1'b1, 1'b1);
    drain("skew_fast");
    send_frame(8'h96, 10.3, 1, 1'b1, 1'b1);
    send_frame(8'h96, 10.3, 1, 1'b1, 1'b1);
    drain("skew_slow");

    // Random bytes, skew, stop bits and gaps
    for (int n = 0; n < 12; n++) begin
      b = 8'($urandom);
      cpb = 9.7 + 0.1 * $urandom_range(0, 6);
      send_frame(b, cpb, $urandom_range(1, 2), 1'b1, 1'b1);
      rx = 1'b1;
      repeat ($urandom_range(0, 5)) @(negedge clk);
    end
    drain("random");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
